// File: rtl/multicycle_sequencer.sv
// Purpose: opcode-driven control sequencer for the multicycle datapath, with memory waits, stall, halt/trap and retire count.
// Latency: IF->IF takes 2 (LDI), 3 (branch/jump), 4 (ALU/store) or 5 (load) edges, plus one per memory wait cycle.
// Backpressure: mem_ready=0 holds IF/LD4/ST4 (watchdog may trap); stall=1 freezes state, wait counter and retired_count.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   opcode         - instruction-register opcode (6 bits)
//   mem_ready      - memory access completes this cycle
//   stall          - freeze the sequencer this cycle
//   state          - current control state (4-bit legacy encoding)
//   retire         - one-cycle pulse in the first IF cycle after an instruction completes
//   retired_count  - retired instructions, wraps modulo 2^CNT_W
//   trap_cause     - 00 none, 01 illegal opcode, 10 memory timeout; latched on TRAP entry
//   halted         - high while in HALT or TRAP
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             stall,
    output logic [3:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count,
    output logic [1:0]       trap_cause,
    output logic             halted
);

    // Encoding is shared with the existing datapath control decode.
    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_RF      = 4'd1;
    localparam logic [3:0] S_IMM2    = 4'd2;
    localparam logic [3:0] S_ALU_R3  = 4'd3;
    localparam logic [3:0] S_ALU_RI3 = 4'd4;
    localparam logic [3:0] S_ALU4    = 4'd5;
    localparam logic [3:0] S_BR3     = 4'd6;
    localparam logic [3:0] S_MEM3    = 4'd7;
    localparam logic [3:0] S_LD4     = 4'd8;
    localparam logic [3:0] S_ST4     = 4'd9;
    localparam logic [3:0] S_LD5     = 4'd10;
    localparam logic [3:0] S_J3      = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd12;
    localparam logic [3:0] S_TRAP    = 4'd13;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [5:0] OP_LDI  = 6'b111110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam bit              WDOG_EN   = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_d;
    logic [3:0]        state_d;
    logic [1:0]        cause_d;
    logic              in_wait_state;
    logic              timeout;
    logic              completing;

    always_comb begin
        state_d       = state;
        cause_d       = CAUSE_NONE;
        in_wait_state = (state == S_IF) || (state == S_LD4) || (state == S_ST4);
        timeout       = WDOG_EN && in_wait_state && !mem_ready && (wait_cnt == TIMEOUT_V);

        case (state)
            S_IF: begin
                if (mem_ready) begin
                    if (opcode == OP_LDI) begin
                        state_d = S_IMM2;
                    end else if (opcode == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (opcode[5:3] == 3'b111) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = S_RF;
                    end
                end
            end
            S_RF: begin
                if (!opcode[5]) begin
                    state_d = opcode[4] ? S_ALU_RI3 : S_ALU_R3;
                end else begin
                    case (opcode[4:3])
                        2'b00:   state_d = S_BR3;
                        2'b01:   state_d = S_MEM3;
                        2'b10:   state_d = S_J3;
                        // 111xxx is resolved at IF; seeing it here means the
                        // opcode changed under us, treat it as illegal.
                        default: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end
            S_ALU_R3, S_ALU_RI3: state_d = S_ALU4;
            S_MEM3:              state_d = opcode[2] ? S_ST4 : S_LD4;
            S_LD4:               if (mem_ready) state_d = S_LD5;
            S_ST4:               if (mem_ready) state_d = S_IF;
            S_IMM2, S_ALU4, S_BR3, S_LD5, S_J3: state_d = S_IF;
            S_HALT, S_TRAP:      state_d = state;
            default: begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        if (timeout) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end

        // Stall wins over everything, including memory completion and timeout.
        if (stall) begin
            state_d = state;
        end

        // Only terminal states (and ST4 on completion) ever move into IF.
        completing = !stall && (state != S_IF) && (state_d == S_IF);

        if (stall) begin
            wait_d = wait_cnt;
        end else if (state_d != state) begin
            wait_d = '0;
        end else if (in_wait_state && !mem_ready) begin
            // Saturate so a disabled watchdog never sees a wrapped count.
            wait_d = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IF;
            wait_cnt      <= '0;
            retire        <= 1'b0;
            retired_count <= '0;
            trap_cause    <= CAUSE_NONE;
            halted        <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            retire   <= completing;
            halted   <= (state_d == S_HALT) || (state_d == S_TRAP);
            if (completing) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if ((state_d == S_TRAP) && (state != S_TRAP)) begin
                trap_cause <= cause_d;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    localparam logic [5:0] OP_ALUR  = 6'b000001;
    localparam logic [5:0] OP_ALURI = 6'b010000;
    localparam logic [5:0] OP_BR    = 6'b100000;
    localparam logic [5:0] OP_LOAD  = 6'b101000;
    localparam logic [5:0] OP_STORE = 6'b101100;
    localparam logic [5:0] OP_JMP   = 6'b110000;
    localparam logic [5:0] OP_LDI   = 6'b111110;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_ILL   = 6'b111000;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        stall;

    // Default-parameter instance
    logic [3:0]  state_a;
    logic        retire_a;
    logic [15:0] count_a;
    logic [1:0]  cause_a;
    logic        halted_a;

    // MEM_TIMEOUT=4, CNT_W=4 instance
    logic [3:0]  state_b;
    logic        retire_b;
    logic [3:0]  count_b;
    logic [1:0]  cause_b;
    logic        halted_b;

    int n_vec;
    int n_err;

    multicycle_sequencer dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .state         (state_a),
        .retire        (retire_a),
        .retired_count (count_a),
        .trap_cause    (cause_a),
        .halted        (halted_a)
    );

    multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .WAIT_W      (4),
        .CNT_W       (4)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .state         (state_b),
        .retire        (retire_b),
        .retired_count (count_b),
        .trap_cause    (cause_b),
        .halted        (halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        st;
        logic [3:0]  s;
        logic        r;
        logic [15:0] c;
        logic [1:0]  tc;
        logic        h;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [5:0] op, input logic mr, input logic st,
                                input logic [3:0] s, input logic r, input logic [15:0] c,
                                input logic [1:0] tc, input logic h);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.s = s; v.r = r; v.c = c; v.tc = tc; v.h = h;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic mr, input logic st);
        opcode    = op;
        mem_ready = mr;
        stall     = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        stall     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        opcode = 6'd0;
        mem_ready = 1'b0;
        stall = 1'b0;

        // Main flow on dut_a, continuous from reset; expected outputs after each edge.
        tv.push_back(mk(OP_ALUR,  1, 0,  1, 0, 0, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  3, 0, 0, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  5, 0, 0, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  0, 1, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  1, 0,  1, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  1, 0,  7, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  1, 0,  8, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  0, 0,  8, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  0, 0,  8, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  0, 0,  8, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  1, 0, 10, 0, 1, 0, 0));
        tv.push_back(mk(OP_LOAD,  1, 0,  0, 1, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 0,  1, 0, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 1,  1, 0, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 1,  1, 0, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 0,  4, 0, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 0,  5, 0, 2, 0, 0));
        tv.push_back(mk(OP_ALURI, 1, 0,  0, 1, 3, 0, 0));
        tv.push_back(mk(OP_BR,    0, 0,  0, 0, 3, 0, 0));
        tv.push_back(mk(OP_BR,    1, 0,  1, 0, 3, 0, 0));
        tv.push_back(mk(OP_BR,    1, 0,  6, 0, 3, 0, 0));
        tv.push_back(mk(OP_BR,    1, 0,  0, 1, 4, 0, 0));
        tv.push_back(mk(OP_JMP,   1, 0,  1, 0, 4, 0, 0));
        tv.push_back(mk(OP_JMP,   1, 0, 11, 0, 4, 0, 0));
        tv.push_back(mk(OP_JMP,   1, 0,  0, 1, 5, 0, 0));
        tv.push_back(mk(OP_STORE, 1, 0,  1, 0, 5, 0, 0));
        tv.push_back(mk(OP_STORE, 1, 0,  7, 0, 5, 0, 0));
        tv.push_back(mk(OP_STORE, 1, 0,  9, 0, 5, 0, 0));
        tv.push_back(mk(OP_STORE, 1, 0,  0, 1, 6, 0, 0));
        tv.push_back(mk(OP_LDI,   1, 0,  2, 0, 6, 0, 0));
        tv.push_back(mk(OP_LDI,   1, 0,  0, 1, 7, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  1, 0, 7, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  3, 0, 7, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  5, 0, 7, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 1,  5, 0, 7, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 0,  0, 1, 8, 0, 0));
        tv.push_back(mk(OP_ALUR,  1, 1,  0, 0, 8, 0, 0));
        tv.push_back(mk(OP_ILL,   1, 0, 13, 0, 8, 1, 1));

        do_reset();
        chk("rst_state", 0, 32'(state_a), 32'd0);
        chk("rst_retire", 0, 32'(retire_a), 32'd0);
        chk("rst_count", 0, 32'(count_a), 32'd0);
        chk("rst_cause", 0, 32'(cause_a), 32'd0);
        chk("rst_halted", 0, 32'(halted_a), 32'd0);
        chk("rst_state_b", 0, 32'(state_b), 32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].op, tv[i].mr, tv[i].st);
            chk("state", i, 32'(state_a), 32'(tv[i].s));
            chk("retire", i, 32'(retire_a), 32'(tv[i].r));
            chk("count", i, 32'(count_a), 32'(tv[i].c));
            chk("cause", i, 32'(cause_a), 32'(tv[i].tc));
            chk("halted", i, 32'(halted_a), 32'(tv[i].h));
        end

        // TRAP is absorbing regardless of inputs.
        for (int i = 0; i < 10; i++) begin
            step(6'(i * 7), 1'(i % 2), 1'b0);
            chk("trap_hold_state", i, 32'(state_a), 32'd13);
            chk("trap_hold_cause", i, 32'(cause_a), 32'd1);
            chk("trap_hold_halted", i, 32'(halted_a), 32'd1);
        end

        // Store timeout with MEM_TIMEOUT=4, stall parked on the trigger cycle.
        do_reset();
        step(OP_STORE, 1'b1, 1'b0);
        chk("st_rf", 0, 32'(state_b), 32'd1);
        step(OP_STORE, 1'b1, 1'b0);
        chk("st_mem3", 0, 32'(state_b), 32'd7);
        step(OP_STORE, 1'b0, 1'b0);
        chk("st_st4", 0, 32'(state_b), 32'd9);
        for (int i = 1; i <= 4; i++) begin
            step(OP_STORE, 1'b0, 1'b0);
            chk("st_wait_state", i, 32'(state_b), 32'd9);
            chk("st_wait_halted", i, 32'(halted_b), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step(OP_STORE, 1'b0, 1'b1);
            chk("st_stall_state", i, 32'(state_b), 32'd9);
        end
        step(OP_STORE, 1'b0, 1'b0);
        chk("to_state", 0, 32'(state_b), 32'd13);
        chk("to_cause", 0, 32'(cause_b), 32'd2);
        chk("to_halted", 0, 32'(halted_b), 32'd1);
        chk("to_count", 0, 32'(count_b), 32'd0);

        // 16 LDIs wrap the 4-bit counter, then HALT, then async reset.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(OP_LDI, 1'b1, 1'b0);
            chk("ldi_imm2", i, 32'(state_b), 32'd2);
            step(OP_LDI, 1'b1, 1'b0);
            chk("ldi_if", i, 32'(state_b), 32'd0);
            chk("ldi_retire", i, 32'(retire_b), 32'd1);
            chk("ldi_count", i, 32'(count_b), 32'(i % 16));
        end
        step(OP_HALT, 1'b1, 1'b0);
        chk("halt_state", 0, 32'(state_b), 32'd12);
        chk("halt_halted", 0, 32'(halted_b), 32'd1);
        chk("halt_retire", 0, 32'(retire_b), 32'd0);
        chk("halt_cause", 0, 32'(cause_b), 32'd0);
        step(OP_LDI, 1'b1, 1'b0);
        chk("halt_hold", 0, 32'(state_b), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 0, 32'(state_b), 32'd0);
        chk("arst_halted", 0, 32'(halted_b), 32'd0);
        chk("arst_count", 0, 32'(count_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
